rgb_channel_pipeline: RTL and testbench

//  Parametrised, pipelined successor to the 1-bit-per-channel RGB decoder. Converts IN_W-bit R/G/B to
//  OUT_W-bit R/G/B using one of three runtime modes: replicate/truncate, threshold, or 2x2 ordered dither.

---
 rtl/rgb_pkg.sv | 21 ++
 rtl/rgb_channel_map.sv | 50 +++++
 rtl/rgb_channel_pipeline.sv | 100 ++++++++++
 tb/tb_rgb_channel_pipeline.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared types for the RGB channel pipeline: mode encoding, sideband bundle
// and the 2x2 ordered-dither matrix.
package rgb_pkg;

    typedef enum logic [1:0] {
        RGB_REPL   = 2'd0,
        RGB_THRESH = 2'd1,
        RGB_DITHER = 2'd2,
        RGB_RSVD   = 2'd3
    } rgb_mode_t;

    typedef struct packed {
        logic active;
        logic sol;
        logic sof;
    } rgb_side_t;

    // Indexed by {row, col}
    localparam logic [1:0] BAYER2 [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

endpackage

// File: rtl/rgb_channel_map.sv
// Combinational map of one IN_W-bit colour channel to OUT_W bits:
// replicate/truncate, threshold, or 2x2 ordered dither with saturation.
module rgb_channel_map
    import rgb_pkg::*;
#(
    parameter int IN_W   = 1,
    parameter int OUT_W  = 4,
    parameter int THRESH = 2**(IN_W-1)
) (
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  v,
    input  logic [1:0]       b,
    output logic [OUT_W-1:0] out
);

    localparam int D   = IN_W - OUT_W;
    localparam int DS  = (D > 0) ? D : 0;
    localparam int SHL = (D >= 2) ? D - 2 : 0;
    localparam int SHR = (D >= 2) ? 0 : 2 - D;
    localparam logic [9:0] VMAX = 10'(2**IN_W - 1);
    localparam logic [9:0] THR  = 10'(THRESH);

    logic [OUT_W-1:0] rep, base, thr, dith;
    logic [9:0]       off, sum, sat;

    // MSB-first replication: output bit k takes input bit (IN_W-1 - k mod IN_W)
    always_comb begin
        rep = '0;
        for (int i = 0; i < OUT_W; i++)
            rep[OUT_W-1-i] = v[IN_W-1-(i % IN_W)];
    end

    assign base = (OUT_W >= IN_W) ? rep : OUT_W'(v >> DS);
    assign thr  = (10'(v) >= THR) ? '1 : '0;

    // Dither offset scaled to the dropped bits; sum saturates instead of wrapping
    assign off  = (10'(b) << SHL) >> SHR;
    assign sum  = 10'(v) + off;
    assign sat  = (sum > VMAX) ? VMAX : sum;
    assign dith = OUT_W'(sat >> DS);

    always_comb begin
        case (rgb_mode_t'(mode))
            RGB_THRESH: out = thr;
            RGB_DITHER: out = (D > 0) ? dith : base;
            default:    out = base;
        endcase
    end

endmodule

// File: rtl/rgb_channel_pipeline.sv
// Two-stage valid/ready RGB depth converter with blanking and Bayer position
// tracking. S1 holds the raw beat, S2 holds the mapped pixel driven to the DAC.
module rgb_channel_pipeline
    import rgb_pkg::*;
#(
    parameter int IN_W   = 1,
    parameter int OUT_W  = 4,
    parameter int THRESH = 2**(IN_W-1)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [IN_W-1:0]  IN_RED,
    input  logic [IN_W-1:0]  IN_GREEN,
    input  logic [IN_W-1:0]  IN_BLUE,
    input  logic             IN_ACTIVE,
    input  logic             IN_SOL,
    input  logic             IN_SOF,
    input  logic [1:0]       CFG_MODE,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [OUT_W-1:0] OUT_RED,
    output logic [OUT_W-1:0] OUT_GREEN,
    output logic [OUT_W-1:0] OUT_BLUE,
    output logic             OUT_ACTIVE,
    output logic             OUT_SOL,
    output logic             OUT_SOF
);

    logic [2:1]             vld_pipe;
    logic                   advance, accept;
    logic                   col, row, col_q, row_q;
    logic [1:0]             bay, s1_mode, s1_b;
    logic [2:0][IN_W-1:0]   in_rgb, s1_rgb;
    logic [2:0][OUT_W-1:0]  map_rgb, s2_rgb;
    rgb_side_t              in_side, s1_side, s2_side;

    assign advance  = !vld_pipe[2] || OUT_READY;
    assign IN_READY = advance;
    assign accept   = IN_VALID && advance;

    assign col = IN_SOL ? 1'b0 : col_q;
    assign row = IN_SOF ? 1'b0 : (IN_SOL ? ~row_q : row_q);
    assign bay = BAYER2[{row, col}];

    assign in_rgb  = {IN_BLUE, IN_GREEN, IN_RED};
    assign in_side = '{active: IN_ACTIVE, sol: IN_SOL, sof: IN_SOF};

    for (genvar c = 0; c < 3; c++) begin : g_ch
        rgb_channel_map #(
            .IN_W   (IN_W),
            .OUT_W  (OUT_W),
            .THRESH (THRESH)
        ) u_map (
            .mode (s1_mode),
            .v    (s1_rgb[c]),
            .b    (s1_b),
            .out  (map_rgb[c])
        );
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            vld_pipe <= '0;
            col_q    <= 1'b0;
            row_q    <= 1'b0;
            s1_rgb   <= '0;
            s1_mode  <= '0;
            s1_b     <= '0;
            s1_side  <= '0;
            s2_rgb   <= '0;
            s2_side  <= '0;
        end else begin
            // Blank beats keep the column parity so dither phase survives blanking
            if (accept) begin
                row_q <= row;
                col_q <= IN_ACTIVE ? ~col : col;
            end
            if (advance) begin
                vld_pipe <= {vld_pipe[1], IN_VALID};
                s1_rgb   <= in_rgb;
                s1_mode  <= CFG_MODE;
                s1_b     <= bay;
                s1_side  <= in_side;
                s2_rgb   <= s1_side.active ? map_rgb : '0;
                s2_side  <= s1_side;
            end
        end
    end

    assign OUT_VALID  = vld_pipe[2];
    assign OUT_RED    = s2_rgb[0];
    assign OUT_GREEN  = s2_rgb[1];
    assign OUT_BLUE   = s2_rgb[2];
    assign OUT_ACTIVE = s2_side.active;
    assign OUT_SOL    = s2_side.sol;
    assign OUT_SOF    = s2_side.sof;

endmodule

// File: tb/tb_rgb_channel_pipeline.sv
// Bench: 8->4 pipeline checked every output cycle against a queue model;
// 1->4 and 3->8 instances share the handshake and are pinned with literals.
module tb_rgb_channel_pipeline;

    logic       CLK = 1'b0;
    logic       RESET_N, IN_VALID, IN_ACTIVE, IN_SOL, IN_SOF, OUT_READY;
    logic [1:0] CFG_MODE;
    logic [7:0] r, g, b;

    logic       in_ready, out_valid, o_act, o_sol, o_sof;
    logic [3:0] o_r, o_g, o_b;
    logic       l_ready, l_valid, l_act, l_sol, l_sof;
    logic [3:0] l_r, l_g, l_b;
    logic       t_ready, t_valid, t_act, t_sol, t_sof;
    logic [7:0] t_r, t_g, t_b;

    always #5 CLK = ~CLK;

    rgb_channel_pipeline #(.IN_W(8), .OUT_W(4)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(in_ready),
        .IN_RED(r), .IN_GREEN(g), .IN_BLUE(b),
        .IN_ACTIVE(IN_ACTIVE), .IN_SOL(IN_SOL), .IN_SOF(IN_SOF), .CFG_MODE(CFG_MODE),
        .OUT_VALID(out_valid), .OUT_READY(OUT_READY),
        .OUT_RED(o_r), .OUT_GREEN(o_g), .OUT_BLUE(o_b),
        .OUT_ACTIVE(o_act), .OUT_SOL(o_sol), .OUT_SOF(o_sof));

    rgb_channel_pipeline #(.IN_W(1), .OUT_W(4)) u_leg (
        .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(l_ready),
        .IN_RED(r[7]), .IN_GREEN(g[7]), .IN_BLUE(b[7]),
        .IN_ACTIVE(IN_ACTIVE), .IN_SOL(IN_SOL), .IN_SOF(IN_SOF), .CFG_MODE(CFG_MODE),
        .OUT_VALID(l_valid), .OUT_READY(OUT_READY),
        .OUT_RED(l_r), .OUT_GREEN(l_g), .OUT_BLUE(l_b),
        .OUT_ACTIVE(l_act), .OUT_SOL(l_sol), .OUT_SOF(l_sof));

    rgb_channel_pipeline #(.IN_W(3), .OUT_W(8)) u_wide (
        .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(t_ready),
        .IN_RED(r[7:5]), .IN_GREEN(g[7:5]), .IN_BLUE(b[7:5]),
        .IN_ACTIVE(IN_ACTIVE), .IN_SOL(IN_SOL), .IN_SOF(IN_SOF), .CFG_MODE(CFG_MODE),
        .OUT_VALID(t_valid), .OUT_READY(OUT_READY),
        .OUT_RED(t_r), .OUT_GREEN(t_g), .OUT_BLUE(t_b),
        .OUT_ACTIVE(t_act), .OUT_SOL(t_sol), .OUT_SOF(t_sof));

    typedef struct {
        logic [3:0] r, g, b;
        logic       act, sol, sof;
    } exp_t;
    typedef struct {
        logic [3:0] r, g, b, lr, lg, lb;
        logic [7:0] tr, tg, tb;
    } got_t;

    exp_t exp_q[$];
    got_t got_q[$];
    exp_t e;
    got_t gt;
    int   n_cmp = 0, n_bad = 0;
    int   mcol, mrow, pc, pr, g0;
    int   bayer_tab [2][2] = '{'{0, 2}, '{3, 1}};

    // Reference: 8-bit in, 4-bit out, threshold 128, dither offset = bayer*4
    function automatic logic [3:0] ref_ch(input logic [7:0] v, input int mode,
                                          input int bay, input logic act);
        int s;
        if (!act) return 4'h0;
        case (mode)
            1: return (v >= 8'd128) ? 4'hF : 4'h0;
            2: begin
                s = int'(v) + bay * 4;
                if (s > 255) s = 255;
                return 4'(s / 16);
            end
            default: return 4'(v / 16);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Model: track transfers at the clock edge, derive expected pixels from the rules
    always @(posedge CLK) begin
        if (RESET_N !== 1'b1) begin
            exp_q.delete();
            mcol = 0;
            mrow = 0;
        end else begin
            if (out_valid === 1'b1 && OUT_READY) begin
                gt = '{o_r, o_g, o_b, l_r, l_g, l_b, t_r, t_g, t_b};
                got_q.push_back(gt);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (IN_VALID && in_ready === 1'b1) begin
                pc = IN_SOL ? 0 : mcol;
                pr = IN_SOF ? 0 : (IN_SOL ? 1 - mrow : mrow);
                e.r = ref_ch(r, int'(CFG_MODE), bayer_tab[pr][pc], IN_ACTIVE);
                e.g = ref_ch(g, int'(CFG_MODE), bayer_tab[pr][pc], IN_ACTIVE);
                e.b = ref_ch(b, int'(CFG_MODE), bayer_tab[pr][pc], IN_ACTIVE);
                e.act = IN_ACTIVE;
                e.sol = IN_SOL;
                e.sof = IN_SOF;
                exp_q.push_back(e);
                mrow = pr;
                mcol = IN_ACTIVE ? 1 - pc : pc;
            end
        end
    end

    // Compare: every cycle the output is valid, it must equal the oldest in-flight beat
    always @(negedge CLK) begin
        if (RESET_N === 1'b1 && out_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL spurious_out: got valid beat, expected none");
            end else if ({o_r, o_g, o_b, o_act, o_sol, o_sof} !==
                         {exp_q[0].r, exp_q[0].g, exp_q[0].b,
                          exp_q[0].act, exp_q[0].sol, exp_q[0].sof}) begin
                n_bad++;
                $display("FAIL model_out: got %h %h %h a%b l%b f%b expected %h %h %h a%b l%b f%b",
                         o_r, o_g, o_b, o_act, o_sol, o_sof,
                         exp_q[0].r, exp_q[0].g, exp_q[0].b,
                         exp_q[0].act, exp_q[0].sol, exp_q[0].sof);
            end
        end
    end

    task automatic present(input logic [7:0] rr, gg, bb, input logic act, sol, sof,
                           input logic [1:0] md);
        @(negedge CLK);
        r = rr; g = gg; b = bb;
        IN_ACTIVE = act; IN_SOL = sol; IN_SOF = sof; CFG_MODE = md;
        IN_VALID = 1'b1;
    endtask

    task automatic wait_acc(input string nm);
        int n = 0;
        #1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (n >= 50) chk({nm, "_accept_timeout"}, 0, 1);
        @(posedge CLK);
    endtask

    task automatic send(input logic [7:0] rr, gg, bb, input logic act, sol, sof,
                        input logic [1:0] md);
        present(rr, gg, bb, act, sol, sof, md);
        wait_acc("send");
    endtask

    task automatic idle();
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge CLK);
            n++;
        end
        if (n >= 100) chk({nm, "_drain_timeout"}, 0, 1);
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET_N = 1'b0; IN_VALID = 1'b0; IN_ACTIVE = 1'b0; IN_SOL = 1'b0; IN_SOF = 1'b0;
        CFG_MODE = 2'd0; OUT_READY = 1'b1; r = '0; g = '0; b = '0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_red", o_r, 0);
        chk("reset_ready", in_ready, 1);
        chk("reset_wide_red", t_r, 0);

        // Threshold on 1-bit legacy and 8-bit instances, 2-cycle latency
        present(8'h80, 8'h7F, 8'hFF, 1'b1, 1'b1, 1'b1, 2'd1);
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
        chk("t1_valid_after1", out_valid, 0);
        @(negedge CLK);
        chk("t1_valid_after2", out_valid, 1);
        chk("t1_leg_rgb", {l_r, l_g, l_b}, 12'hF0F);
        chk("t1_main_rgb", {o_r, o_g, o_b}, 12'hF0F);
        drain("t1");

        // Replicate (3->8) and truncate (8->4)
        g0 = got_q.size();
        send(8'hA7, 8'h60, 8'hE0, 1'b1, 1'b1, 1'b0, 2'd0);
        idle();
        drain("t2");
        chk("t2_trunc_rgb", {got_q[g0].r, got_q[g0].g, got_q[g0].b}, 12'hA6E);
        chk("t2_wide_rgb", {got_q[g0].tr, got_q[g0].tg, got_q[g0].tb}, 24'hB66DFF);
        chk("t2_leg_rgb", {got_q[g0].lr, got_q[g0].lg, got_q[g0].lb}, 12'hF0F);

        // Dither across a 2x2 tile, then saturation at (1,0)
        g0 = got_q.size();
        send(8'h08, 8'h08, 8'h08, 1'b1, 1'b1, 1'b1, 2'd2);
        send(8'h08, 8'h08, 8'h08, 1'b1, 1'b0, 1'b0, 2'd2);
        send(8'h08, 8'h08, 8'h08, 1'b1, 1'b1, 1'b0, 2'd2);
        send(8'h08, 8'h08, 8'h08, 1'b1, 1'b0, 1'b0, 2'd2);
        send(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2);
        send(8'hFF, 8'hF5, 8'h30, 1'b1, 1'b1, 1'b0, 2'd2);
        idle();
        drain("t3");
        chk("t3_dither_seq", {got_q[g0].r, got_q[g0+1].r, got_q[g0+2].r, got_q[g0+3].r}, 16'h0110);
        chk("t3_saturate", {got_q[g0+5].r, got_q[g0+5].g, got_q[g0+5].b}, 12'hFF3);

        // Backpressure: two beats fill the pipe, third is held off
        @(negedge CLK);
        OUT_READY = 1'b0;
        g0 = got_q.size();
        send(8'h10, 8'h11, 8'h12, 1'b1, 1'b1, 1'b0, 2'd0);
        send(8'h20, 8'h21, 8'h22, 1'b1, 1'b0, 1'b0, 2'd0);
        present(8'h30, 8'h31, 8'h32, 1'b1, 1'b0, 1'b0, 2'd0);
        #1;
        chk("t4_ready_low", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            #1;
            chk("t4_stall_ready", in_ready, 0);
            chk("t4_stall_hold", {out_valid, o_r}, {1'b1, 4'h1});
        end
        OUT_READY = 1'b1;
        wait_acc("t4");
        send(8'h40, 8'h41, 8'h42, 1'b1, 1'b0, 1'b0, 2'd0);
        idle();
        drain("t4");
        chk("t4_count", got_q.size() - g0, 4);
        chk("t4_order", {got_q[g0].r, got_q[g0+1].r, got_q[g0+2].r, got_q[g0+3].r}, 16'h1234);

        // Blanking zeroes output and does not advance column parity
        g0 = got_q.size();
        send(8'h08, 8'h08, 8'h08, 1'b1, 1'b0, 1'b1, 2'd2);
        send(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 2'd2);
        send(8'h08, 8'h08, 8'h08, 1'b1, 1'b0, 1'b0, 2'd2);
        idle();
        drain("t5");
        chk("t5_blank_rgb", {got_q[g0+1].r, got_q[g0+1].g, got_q[g0+1].b}, 12'h000);
        chk("t5_after_blank", {got_q[g0].r, got_q[g0+2].r}, 8'h01);

        // Reset with both stages full, then parity restarts and mode 3 acts as mode 0
        @(negedge CLK);
        OUT_READY = 1'b0;
        send(8'h08, 8'h08, 8'h08, 1'b1, 1'b0, 1'b1, 2'd2);
        send(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 2'd2);
        idle();
        #1;
        chk("t6_full_valid", out_valid, 1);
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        chk("t6_reset_valid", out_valid, 0);
        chk("t6_reset_ready", in_ready, 1);
        OUT_READY = 1'b1;
        g0 = got_q.size();
        send(8'h0C, 8'h0C, 8'h0C, 1'b1, 1'b0, 1'b0, 2'd2);
        send(8'hA7, 8'h60, 8'hE0, 1'b1, 1'b0, 1'b0, 2'd3);
        idle();
        drain("t6");
        chk("t6_count", got_q.size() - g0, 2);
        chk("t6_first_b0", got_q[g0].r, 4'h0);
        chk("t6_mode3_main", {got_q[g0+1].r, got_q[g0+1].g, got_q[g0+1].b}, 12'hA6E);
        chk("t6_mode3_wide", {got_q[g0+1].tr, got_q[g0+1].tg, got_q[g0+1].tb}, 24'hB66DFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
